multicycle_controller: RTL and testbench

Multicycle sequencer for the 32-bit ARM core. It replaces the single-cycle control path with a Moore state machine that walks each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles on a shared ALU and unified memory port. It embeds ALU decoding, the NZCV flag register and condition evaluation, and drives every datapath mux select and write enable.

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM through fetch/decode/execute/memory/writeback,
// with embedded ALU decode, NZCV flag register and condition evaluation.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] flags;
    logic       cond_ex;
    logic       cond_ex_q;
    logic [1:0] alu_op;
    logic       is_cmp;
    logic [1:0] flag_w;
    logic       alu_dec;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       rd_is_pc;

    // State, stored flags and latched condition result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cond_ex_q <= cond_ex;
            end
            if ((state == S_EXECUTER) || (state == S_EXECUTEI)) begin
                if (flag_w[1] && cond_ex_q) begin
                    flags[3:2] <= ALUFlags[3:2];
                end
                if (flag_w[0] && cond_ex_q) begin
                    flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // ALU operation decode from Funct[4:1]; CMP is a SUB without writeback
    always_comb begin
        alu_op = 2'b00;
        is_cmp = 1'b0;
        case (Funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            4'b1010: begin
                alu_op = 2'b01;
                is_cmp = 1'b1;
            end
            default: alu_op = 2'b00;
        endcase
    end

    assign flag_w = {Funct[0], Funct[0] & ~alu_op[1]};

    // ARM condition evaluation against stored {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    assign rd_is_pc = (Rd == 4'd15);

    // Next-state and Moore output decode
    always_comb begin
        next_state    = S_FETCH;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        alu_dec       = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    2'b01:   next_state = S_MEMADR;
                    2'b00:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = cond_ex_q;
                pc_write_raw  = cond_ex_q & rd_is_pc;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = cond_ex_q;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state == S_EXECUTEI) ? 2'b01 : 2'b00;
                alu_dec    = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = cond_ex_q & ~is_cmp;
                pc_write_raw  = cond_ex_q & ~is_cmp & rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                pc_write_raw = cond_ex_q;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign ALUControl = alu_dec ? alu_op : 2'b00;
    assign PCWrite    = rst_n & pc_write_raw;
    assign IRWrite    = rst_n & ir_write_raw;
    assign RegWrite   = rst_n & reg_write_raw;
    assign MemWrite   = rst_n & mem_write_raw;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign State      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model predicts every
// cycle's state and control outputs, and a negedge process compares them.
module tb_multicycle_controller;
    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] rsrc;
        logic [1:0] aluc;
        logic [1:0] imm;
        logic [1:0] regsrc;
    } vec_t;

    vec_t       exp_q[$];
    vec_t       seq[$];
    vec_t       act;
    logic [3:0] m_flags;
    logic [3:0] m_next_flags;
    logic       rst_check;
    int         tests;
    int         fails;
    int         n;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic nf, zf, cf, vf;
        {nf, zf, cf, vf} = f;
        case (c)
            4'h0: return zf;
            4'h1: return !zf;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return nf;
            4'h5: return !nf;
            4'h6: return vf;
            4'h7: return !vf;
            4'h8: return cf && !zf;
            4'h9: return !cf || zf;
            4'hA: return nf == vf;
            4'hB: return nf != vf;
            4'hC: return !zf && (nf == vf);
            4'hD: return zf || (nf != vf);
            default: return 1'b1;
        endcase
    endfunction

    function automatic vec_t blank(input logic [3:0] st, input logic [1:0] op);
        vec_t v;
        v        = '0;
        v.st     = st;
        v.imm    = op;
        v.regsrc = {op == 2'b01, op == 2'b10};
        return v;
    endfunction

    // Expected per-cycle outputs for one whole instruction, plus the flags it leaves behind
    function automatic void build(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                                  input logic [3:0] rd, input logic [3:0] af);
        logic       ce;
        logic       cmp;
        logic [1:0] aluc;
        vec_t       v;
        seq.delete();
        ce           = cond_true(c, m_flags);
        m_next_flags = m_flags;
        v = blank(4'd0, op); v.pcw = 1'b1; v.irw = 1'b1; v.srca = 1'b1;
        v.srcb = 2'b10; v.rsrc = 2'b10; seq.push_back(v);
        v = blank(4'd1, op); v.srca = 1'b1; v.srcb = 2'b10; seq.push_back(v);
        if (op == 2'b01) begin
            v = blank(4'd2, op); v.srcb = 2'b01; seq.push_back(v);
            if (f[0]) begin
                v = blank(4'd3, op); v.adr = 1'b1; seq.push_back(v);
                v = blank(4'd4, op); v.rsrc = 2'b01; v.rw = ce; v.pcw = ce && (rd == 4'd15);
                seq.push_back(v);
            end else begin
                v = blank(4'd5, op); v.adr = 1'b1; v.mw = ce; seq.push_back(v);
            end
        end else if (op == 2'b00) begin
            cmp = 1'b0;
            case (f[4:1])
                4'b0010: aluc = 2'b01;
                4'b0000: aluc = 2'b10;
                4'b1100: aluc = 2'b11;
                4'b1010: begin aluc = 2'b01; cmp = 1'b1; end
                default: aluc = 2'b00;
            endcase
            v = blank(f[5] ? 4'd7 : 4'd6, op); v.srcb = f[5] ? 2'b01 : 2'b00; v.aluc = aluc;
            seq.push_back(v);
            v = blank(4'd8, op); v.rw = ce && !cmp; v.pcw = ce && !cmp && (rd == 4'd15);
            seq.push_back(v);
            if (ce && f[0]) begin
                m_next_flags[3:2] = af[3:2];
                if (aluc == 2'b00 || aluc == 2'b01) m_next_flags[1:0] = af[1:0];
            end
        end else if (op == 2'b10) begin
            v = blank(4'd9, op); v.srcb = 2'b01; v.rsrc = 2'b10; v.pcw = ce; seq.push_back(v);
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        vec_t e;
        if (rst_check) begin
            tests++;
            if (State !== 4'd0 || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_state @%0t: State=%0d enables=%b, required State=0 enables=0000",
                         $time, State, {PCWrite, IRWrite, RegWrite, MemWrite});
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle_outputs @%0t: got st=%0d vec=%05h, required st=%0d vec=%05h",
                         $time, act.st, act, e.st, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            rst_check = 1'b1;
        end
        @(negedge clk);
        #1;
        rst_check = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_flags = 4'b0000;
    endtask

    // Runs one instruction from FETCH; keep < full length aborts it part-way
    task automatic run(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af, input int keep, output int len);
        int k;
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        build(c, op, f, rd, af);
        len = seq.size();
        k   = (keep < 0 || keep > len) ? len : keep;
        for (int i = 0; i < k; i++) exp_q.push_back(seq[i]);
        repeat (k) @(posedge clk);
        #1;
        if (k == len) m_flags = m_next_flags;
    endtask

    initial begin
        tests = 0; fails = 0; rst_check = 1'b0; m_flags = 4'b0000;
        rst_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; ALUFlags = 4'b0000;
        do_reset(3);
        run(4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, -1, n); chk("dp_cycles", n, 5'd4);
        chk("flags_after_adds", m_flags, 4'b0100);
        run(4'hE, 2'b00, 6'b010101, 4'd0,  4'b0110, -1, n); chk("flags_after_cmp", m_flags, 4'b0110);
        run(4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n); chk("b_cycles", n, 5'd3);
        chk("beq_taken", seq[2].pcw, 1'b1);
        run(4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, -1, n); chk("ldr_cycles", n, 5'd5);
        run(4'hE, 2'b00, 6'b001001, 4'd2,  4'b0000, -1, n); chk("flags_cleared", m_flags, 4'b0000);
        run(4'h0, 2'b01, 6'b011000, 4'd3,  4'b0000, -1, n); chk("str_cycles", n, 5'd4);
        chk("str_skipped", seq[3].mw, 1'b0);
        run(4'hE, 2'b11, 6'b011000, 4'd3,  4'b0000, -1, n); chk("undef_cycles", n, 5'd2);
        run(4'hE, 2'b00, 6'b000101, 4'd4,  4'b1001, -1, n); chk("flags_after_subs", m_flags, 4'b1001);
        run(4'h4, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'hA, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'hB, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'h8, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'h9, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'hE, 2'b00, 6'b100001, 4'd5,  4'b0110, -1, n); chk("flags_after_ands", m_flags, 4'b0101);
        run(4'hE, 2'b00, 6'b011000, 4'd15, 4'b1111, -1, n);
        run(4'h1, 2'b00, 6'b001000, 4'd15, 4'b1111, -1, n);
        run(4'h1, 2'b00, 6'b001001, 4'd6,  4'b1111, -1, n); chk("flags_not_taken", m_flags, 4'b0101);
        run(4'hE, 2'b00, 6'b001100, 4'd7,  4'b0000, -1, n);
        run(4'hE, 2'b01, 6'b011000, 4'd7,  4'b0000, -1, n);
        run(4'h0, 2'b01, 6'b011001, 4'd3,  4'b0000, -1, n);
        run(4'hF, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        run(4'hE, 2'b00, 6'b101001, 4'd1,  4'b1111, 3, n);
        do_reset(1);
        run(4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n); chk("beq_after_reset", seq[2].pcw, 1'b0);
        run(4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, -1, n);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
